// File: rtl/keypad_encoder.sv
// Key-matrix front end: synchronizes and debounces the 5x7 ROW/COL lines and queues one code per press.
// Optional macro KEYPAD_AUTOREPEAT_EN re-pushes a held key every REPEAT_CYCLES cycles.
module keypad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 25000000
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] row,
  input  logic [6:0] col,
  output logic [5:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [11:0]   sync1, sync2;
  logic          pat_valid, pat_idle;
  logic [2:0]    ri, ci;
  logic [5:0]    pat_code;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    cand;
  logic          cnt_last, press_push, push, pop, push_ok, full;

  logic [FIFO_DEPTH-1:0][5:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;

  // Lines are released (high) while reset so a held key is seen as a fresh press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {row, col};
      sync2 <= sync1;
    end
  end

  always_comb begin
    pat_valid = ($countones(~sync2[11:7]) == 1) && ($countones(~sync2[6:0]) == 1);
    pat_idle  = &sync2;
    ri = '0;
    ci = '0;
    for (int i = 0; i < 5; i++) if (!sync2[7+i]) ri = 3'(i);
    for (int i = 0; i < 7; i++) if (!sync2[i])   ci = 3'(i);
    pat_code = {3'b0, ri} * 6'd7 + {3'b0, ci};
  end

  assign cnt_last   = (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press_push = (state == DEB_PRESS) && pat_valid && (pat_code == cand) && cnt_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_down <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pat_valid) begin
          cand  <= pat_code;
          cnt   <= '0;
          state <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!pat_valid || pat_code != cand) state <= IDLE;
          else if (cnt_last) begin
            state    <= PRESSED;
            key_down <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        PRESSED: if (pat_idle) begin
          cnt   <= '0;
          state <= DEB_REL;
        end
        DEB_REL: begin
          if (!pat_idle) state <= PRESSED;
          else if (cnt_last) begin
            state    <= IDLE;
            key_down <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rep_cnt;
  logic          rep_fire, in_hold;

  assign in_hold  = (state == PRESSED) && !pat_idle;
  assign rep_fire = in_hold && (rep_cnt == RW'(REPEAT_CYCLES - 1));

  // Cleared whenever we are not holding in PRESSED, so every entry starts a full period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      rep_cnt <= '0;
    else if (!in_hold) rep_cnt <= '0;
    else if (rep_fire) rep_cnt <= '0;
    else               rep_cnt <= rep_cnt + 1'b1;
  end

  assign push = press_push || rep_fire;
`else
  assign push = press_push;
`endif

  assign key_valid = (fcnt != '0);
  assign full      = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push && (!full || pop);
  assign key_code  = key_valid ? mem[rd_ptr] : 6'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fcnt <= fcnt + 1'b1;
      else if (pop && !push_ok) fcnt <= fcnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= cand;
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed/randomized bench for keypad_encoder with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_keypad_encoder;
  localparam int DC = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int CLEAN_PUSHES = 2;
  localparam int HOLD_PUSHES  = 4;
`else
  localparam int CLEAN_PUSHES = 1;
  localparam int HOLD_PUSHES  = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] row;
  logic [6:0] col;
  logic [5:0] key_code;
  logic       key_valid, key_ready, key_down, overflow;

  int n_chk = 0, n_pass = 0;
  int got_q[$];
  int exp_q[$];
  int ovf_cnt = 0;
  bit kd_seen = 0;

  keypad_encoder #(
    .DEBOUNCE_CYCLES(DC),
    .FIFO_DEPTH(4)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_CYCLES(10)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Reference: a pattern is a key iff exactly one row and one column are low.
  function automatic int model_code(logic [4:0] r, logic [6:0] c);
    int ri, ci;
    if ($countones(~r) != 1 || $countones(~c) != 1) return -1;
    ri = 0; ci = 0;
    for (int i = 0; i < 5; i++) if (r[i] == 1'b0) ri = i;
    for (int i = 0; i < 7; i++) if (c[i] == 1'b0) ci = i;
    return ri * 7 + ci;
  endfunction

  function automatic logic [11:0] pat_of(int code);
    logic [4:0] r;
    logic [6:0] c;
    r = '1; c = '1;
    r[code / 7] = 1'b0;
    c[code % 7] = 1'b0;
    return {r, c};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Each iteration: note a pop about to happen at the coming edge, then sample #1 after it.
  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      if (key_valid && key_ready) got_q.push_back(int'(key_code));
      @(posedge clock); #1;
      if (overflow) ovf_cnt++;
      if (key_down) kd_seen = 1;
    end
  endtask

  task automatic drive(logic [11:0] p);
    {row, col} = p;
  endtask

  task automatic press(int code, int hold, int rel);
    drive(pat_of(code));
    step(hold);
    drive('1);
    step(rel);
  endtask

  task automatic drain_and_compare(string tag);
    got_q.delete();
    key_ready = 1'b1;
    step(8);
    key_ready = 1'b0;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_code"}, got_q[i], exp_q[i]);
    check({tag, "_empty_valid"}, key_valid, 0);
    check({tag, "_empty_code"}, key_code, 0);
  endtask

  initial begin
    int c5, rc, ec;
    int codes[4];
    reset_n = 1'b0; key_ready = 1'b0;
    drive('1);
    #3;
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_down", key_down, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(3);

    // Clean press: code 17, ready held high
    got_q.delete();
    key_ready = 1'b1;
    row = 5'b11011; col = 7'b1110111;
    ec = model_code(row, col);
    step(6);
    check("clean_valid_e6", key_valid, 0);
    check("clean_down_e6", key_down, 0);
    step(1);
    check("clean_valid_e7", key_valid, 1);
    check("clean_code_e7", key_code, ec);
    check("clean_down_e7", key_down, 1);
    step(1);
    check("clean_valid_e8", key_valid, 0);
    step(12);
    check("clean_pushes", got_q.size(), CLEAN_PUSHES);
    if (got_q.size() > 0) check("clean_popped", got_q[0], ec);
    drive('1);
    step(6);
    check("rel_down_e6", key_down, 1);
    step(1);
    check("rel_down_e7", key_down, 0);
    step(3);

    // Bounce: 3-cycle lows, 2-cycle highs
    got_q.delete(); kd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      row = 5'b11011; col = 7'b1110111;
      step(3);
      drive('1);
      step(2);
    end
    step(10);
    check("bounce_pushes", got_q.size(), 0);
    check("bounce_down", kd_seen, 0);

    // Multi-key pattern
    got_q.delete(); kd_seen = 0;
    row = 5'b11110; col = 7'b1111100;
    ec = (model_code(row, col) >= 0) ? 1 : 0;
    step(20);
    drive('1);
    step(10);
    check("multi_pushes", got_q.size(), ec);
    check("multi_down", kd_seen, ec);

    // Overflow: codes 0..4 with no consumer
    key_ready = 1'b0; ovf_cnt = 0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      press(k, 10, 10);
      exp_q.push_back(k);
    end
    check("ovf_before_5th", ovf_cnt, 0);
    check("ovf_full_head", key_code, 0);
    press(4, 10, 10);
    check("ovf_on_5th", ovf_cnt, 1);
    drain_and_compare("ovf_drain");

    // Full with a pop coinciding with the push: random codes
    ovf_cnt = 0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      codes[k] = $urandom_range(34, 0);
      press(codes[k], 10, 10);
      exp_q.push_back(codes[k]);
    end
    check("full_head", key_code, codes[0]);
    c5 = $urandom_range(34, 0);
    got_q.delete();
    drive(pat_of(c5));
    step(6);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("simul_ovf_pulse", overflow, 0);
    check("simul_popped", got_q.size() > 0 ? got_q[0] : -1, codes[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(c5);
    step(3);
    drive('1);
    step(10);
    check("simul_ovf_cnt", ovf_cnt, 0);
    drain_and_compare("simul_drain");

    // Reset during DEB_PRESS with the key held throughout
    rc = $urandom_range(34, 0);
    drive(pat_of(rc));
    step(4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_down", key_down, 0);
    step(2);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(6);
    check("post_rst_valid_e6", key_valid, 0);
    step(1);
    check("post_rst_valid_e7", key_valid, 1);
    check("post_rst_code_e7", key_code, rc);
    check("post_rst_down_e7", key_down, 1);
    got_q.delete();
    key_ready = 1'b1;
    step(35);
    check("hold_pushes", got_q.size(), HOLD_PUSHES);
    foreach (got_q[i]) check("hold_code", got_q[i], rc);
    drive('1);
    step(10);
    key_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans the calculator's 5×7 key matrix lines and delivers one clean key code per physical key press. It synchronizes and debounces the raw ROW/COL lines, rejects multi-key patterns, and encodes the key index. Codes are buffered in a small FIFO presented to the controller over a valid/ready handshake. It sits upstream of the controller, replacing the raw `ROW`/`COL` reduction currently driving an LED.

## Interface

- `DEBOUNCE_CYCLES`, default 500000: cycles a pattern must be stable to count as a press or release (10 ms at 50 MHz). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: key FIFO entries. Must be a power of two, ≥ 2.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period. Used only with `KEYPAD_AUTOREPEAT_EN`.

Ports:

- `clock` input 1: system clock, 50 MHz.
- `reset_n` input 1: asynchronous, active-low reset.
- `row` input 5: matrix row lines, active-low, asynchronous to `clock`.
- `col` input 7: matrix column lines, active-low, asynchronous to `clock`.
- `key_code` output 6: FIFO head code; 0 when the FIFO is empty.
- `key_valid` output 1: FIFO non-empty.
- `key_ready` input 1: consumer accepts the head this cycle.
- `key_down` output 1: a debounced key is currently held.
- `overflow` output 1: one-cycle pulse when a code is dropped because the FIFO is full.

## Operation

- **Synchronizer.** Two-flop synchronizer on all 12 lines. Reset value is all-ones (released).
- **Valid pattern.** A synchronized pattern is valid only when exactly one `row` bit is low and exactly one `col` bit is low.
  - Code = row_index*7 + col_index, giving the range 0..34. Bit 0 has index 0.
  - "Idle pattern" means all 12 lines are high.
- **FSM states and transitions:**
  - IDLE: on a valid pattern, latch the candidate code, clear the counter, and go to DEB_PRESS. Any other pattern stays in IDLE.
  - DEB_PRESS: if the pattern differs from the candidate, return to IDLE with no push. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 with the pattern still matching, push the candidate and go to PRESSED.
  - PRESSED: on the idle pattern, clear the counter and go to DEB_REL. Any other pattern stays in PRESSED; a second key or a different key produces no push.
  - DEB_REL: any low line returns to PRESSED. When the counter equals DEBOUNCE_CYCLES-1 with the idle pattern, go to IDLE.
- **`key_down`** is high in PRESSED and DEB_REL.
- **FIFO** is first-word-fall-through.
  - Pop occurs when `key_valid && key_ready`.
  - A push when full is dropped and `overflow` pulses, unless a pop happens in the same cycle; in that case the push is accepted.
  - Simultaneous push and pop when non-full: the occupancy count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Reset (asynchronous):** state IDLE, counter 0, FIFO empty.
  - `key_code`=0, `key_valid`=0, `key_down`=0, `overflow`=0.
  - A press in progress is discarded.
  - A key still held when reset is released is debounced and pushed as a new press.

## Timing

- **Press latency.** Count the edge that first samples the pressed lines as edge 1.
  - The FSM enters DEB_PRESS on edge 3.
  - The push happens on edge DEBOUNCE_CYCLES+3.
  - `key_valid` and `key_code` are valid after that edge.
  - `key_down` rises on the same edge.
- **Release.** `key_down` falls DEBOUNCE_CYCLES+3 edges after the lines return high.
- **Handshake.** `key_code` is stable while `key_valid`=1 and `key_ready`=0. After a pop, the next entry appears on the following cycle.
- **Counter width** is $clog2(DEBOUNCE_CYCLES). The counter never wraps because it is cleared on every state entry.

## Configuration

- **`KEYPAD_AUTOREPEAT_EN` defined:**
  - While in PRESSED, a second counter runs.
  - Every REPEAT_CYCLES cycles in PRESSED, the latched code is pushed again, subject to the normal overflow rules.
  - The repeat counter clears on entry to PRESSED and on leaving PRESSED.
- **Not defined:** exactly one push per press. The repeat counter and the REPEAT_CYCLES logic are absent.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.

- **Clean press.** Drive `row`=5'b11011 and `col`=7'b1110111 for 20 cycles, `key_ready`=1.
  - Exactly one `key_valid` cycle with `key_code`=17, after edge 7.
  - `key_down` is high from edge 7 until 7 edges after release.
- **Bounce.** Toggle the same key with low pulses of 3 cycles separated by 2-cycle highs. Result: no push, and `key_down` stays 0.
- **Multi-key.** Drive `row`=5'b11110 and `col`=7'b1111100 for 20 cycles. Result: no push.
- **Overflow.** With `key_ready`=0, press codes 0, 1, 2, 3, 4 in turn.
  - `overflow` pulses once, on the fifth push.
  - With `key_ready`=1 afterwards, codes 0, 1, 2, 3 drain in order, then `key_valid`=0 and `key_code`=0.
- **Full with simultaneous pop.** FIFO full, push coinciding with `key_ready`=1. Result: no `overflow`, and the new code appears last in the drain order.
- **Reset mid-debounce.** Assert `reset_n`=0 during DEB_PRESS for 2 cycles, with the key held throughout.
  - All outputs are 0 during reset.
  - After release, the key pushes once, DEBOUNCE_CYCLES+3 edges later.
  - Run with `KEYPAD_AUTOREPEAT_EN` defined and REPEAT_CYCLES=10, holding the key for 35 cycles past the push: 3 additional pushes, one every 10 cycles.
